mem_req_ctrl: RTL

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl_if.sv | 42 ++++
 rtl/mem_req_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl_if.sv
// Bus bundle for mem_req_ctrl: upstream request, downstream response and
// data SRAM port. The controller takes the slave view, the requester/SRAM side the master view.
interface mem_req_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [2:0]  req_mode;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        data_sram_en;
    logic        data_sram_we;
    logic [2:0]  data_sram_mode;
    logic [1:0]  data_sram_cs;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport slave (
        input  req_valid, req_op, req_mode, req_sign, req_addr, req_wdata,
        input  data_sram_rdata, resp_ready,
        output req_ready,
        output data_sram_en, data_sram_we, data_sram_mode, data_sram_cs,
        output data_sram_addr, data_sram_wdata,
        output resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_op, req_mode, req_sign, req_addr, req_wdata,
        output data_sram_rdata, resp_ready,
        input  req_ready,
        input  data_sram_en, data_sram_we, data_sram_mode, data_sram_cs,
        input  data_sram_addr, data_sram_wdata,
        input  resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-outstanding memory request controller: validates and latches a
// load/store, strobes the data SRAM once, waits out the read latency and returns extended load data.
module mem_req_ctrl #(
    parameter int SRAM_LAT = 1
) (
    input  logic          clk,
    input  logic          resetn,
    mem_req_ctrl_if.slave bus
);
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic             op_reg;
    logic [2:0]       mode_reg;
    logic             sign_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      rdata_reg;
    logic             err_reg;

    logic        accept;
    logic        mode_legal;
    logic        misaligned;
    logic        req_err;
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    logic        en_out;
    logic        we_out;
    logic        resp_valid_out;
    logic        req_ready_out;

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
    assign accept     = (state_reg == IDLE) && bus.req_valid;
    assign mode_legal = (bus.req_mode == 3'b001) || (bus.req_mode == 3'b010) ||
                        (bus.req_mode == 3'b100);
    assign misaligned = ((bus.req_mode == 3'b010) && bus.req_addr[0]) ||
                        ((bus.req_mode == 3'b100) && (bus.req_addr[1:0] != 2'b00));
    assign req_err    = !mode_legal || misaligned;

    // ------------------------------------------------------------------
    // Load extraction from the raw SRAM word
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = bus.data_sram_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_reg[1:0]];
    assign half_sel = addr_reg[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];

    always_comb begin
        load_ext = bus.data_sram_rdata;
        case (mode_reg)
            3'b001:  load_ext = {{24{sign_reg & byte_sel[7]}}, byte_sel};
            3'b010:  load_ext = {{16{sign_reg & half_sel[15]}}, half_sel};
            default: load_ext = bus.data_sram_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = req_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_next = op_reg ? RESP : WAIT;
            end
            WAIT: begin
                // Last WAIT cycle is the one the counter reads as one.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        en_out         = 1'b0;
        we_out         = 1'b0;
        resp_valid_out = 1'b0;
        req_ready_out  = 1'b0;
        case (state_reg)
            IDLE:  req_ready_out  = resetn;
            ISSUE: begin
                en_out = 1'b1;
                we_out = op_reg;
            end
            RESP:  resp_valid_out = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latches, latency counter and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_reg   <= '0;
            op_reg    <= 1'b0;
            mode_reg  <= 3'b000;
            sign_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                op_reg    <= bus.req_op;
                mode_reg  <= bus.req_mode;
                sign_reg  <= bus.req_sign;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
                err_reg   <= req_err;
                rdata_reg <= '0;
            end
            if ((state_reg == ISSUE) && !op_reg) begin
                cnt_reg <= CNT_W'(SRAM_LAT);
            end
            if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    rdata_reg <= load_ext;
                end
            end
        end
    end

    assign bus.req_ready       = req_ready_out;
    assign bus.data_sram_en    = en_out;
    assign bus.data_sram_we    = we_out;
    assign bus.data_sram_mode  = mode_reg;
    assign bus.data_sram_cs    = addr_reg[1:0];
    assign bus.data_sram_addr  = {addr_reg[31:2], 2'b00};
    assign bus.data_sram_wdata = wdata_reg;
    assign bus.resp_valid      = resp_valid_out;
    assign bus.resp_rdata      = rdata_reg;
    assign bus.resp_err        = err_reg;

endmodule
